// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Buffers 12-bit acquisition samples in a circular FIFO. Once a full frame's
// worth of samples is buffered, it feeds a byte-wide UART one byte at a time
// with the frame: SYNC, N, {hi,lo} per sample, XOR checksum.
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous, active-low reset
//   i_sample_valid  push request (written when i_sample_valid & o_sample_ready,
//                   or when full while the head is popped in the same cycle)
//   i_sample_data   12-bit sample
//   o_sample_ready  FIFO not full (combinational from occupancy count)
//   i_frame_len     samples per frame N, sampled only in IDLE; 0 disables
//   i_tx_ready      UART write/ready (1 = idle)
//   o_tx_enable     byte offer to UART enable
//   o_tx_data       byte to UART dataToSend, held for the whole shift-out
//   o_busy          frame in progress
//   o_overflow      sticky: push attempted while full with no pop
// ---------------------------------------------------------------------------
module uart_frame_tx #(
   parameter int         DEPTH = 256,
   parameter logic [7:0] SYNC  = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sample_valid,
   input  logic [11:0] i_sample_data,
   output logic        o_sample_ready,
   input  logic [7:0]  i_frame_len,
   input  logic        i_tx_ready,
   output logic        o_tx_enable,
   output logic [7:0]  o_tx_data,
   output logic        o_busy,
   output logic        o_overflow
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int CMPW = (CW > 8) ? CW : 8;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_HI, S_LO, S_CHK} state_t;
   typedef enum logic {B_OFFER, B_WAIT} sub_t;

   // FIFO storage and control
   logic [11:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   // Sequencer state and registered outputs
   state_t        r_state;
   sub_t          r_sub;
   logic          r_tx_enable;
   logic [7:0]    r_tx_data;
   logic          r_busy;

   // Frame datapath
   logic [7:0]    r_len;
   logic [7:0]    r_remaining;
   logic [7:0]    r_chk;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [11:0]   w_head;
   logic          w_start;
   logic          w_accept;
   logic          w_done;
   state_t        w_state_nxt;
   sub_t          w_sub_nxt;
   logic          w_tx_enable_nxt;
   logic [7:0]    w_tx_data_nxt;
   logic          w_busy_nxt;

   // Byte presented when the sequencer enters a state's OFFER phase.
   function automatic logic [7:0] frame_byte(input state_t s, input logic [7:0] len,
                                             input logic [11:0] head, input logic [7:0] chk);
      logic [7:0] b;
      case (s)
         S_SYNC:  b = SYNC;
         S_LEN:   b = len;
         S_HI:    b = {4'h0, head[11:8]};
         S_LO:    b = head[7:0];
         S_CHK:   b = chk;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign w_full         = (r_count == CW'(DEPTH));
   assign o_sample_ready = ~w_full;
   assign w_head         = r_mem[r_rd_ptr];
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign w_push         = i_sample_valid && (!w_full || w_pop);

   assign w_start  = (r_state == S_IDLE) && (i_frame_len != 8'd0) &&
                     (CMPW'(r_count) >= CMPW'(i_frame_len));
   // OFFER -> WAIT_DONE: the UART has taken the byte and started shifting.
   assign w_accept = (r_state != S_IDLE) && (r_sub == B_OFFER) && !i_tx_ready;
   // WAIT_DONE -> next byte: the UART has finished shifting.
   assign w_done   = (r_state != S_IDLE) && (r_sub == B_WAIT) && i_tx_ready;
   assign w_pop    = w_accept && (r_state == S_LO);

   // ---- FIFO ----------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_sample_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (i_sample_valid && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // ---- Sequencer: state register -------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_sub       <= B_OFFER;
         r_tx_enable <= 1'b0;
         r_tx_data   <= 8'h00;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sub       <= w_sub_nxt;
         r_tx_enable <= w_tx_enable_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // ---- Sequencer: next state -----------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_sub_nxt   = r_sub;
      if (w_start) begin
         w_state_nxt = S_SYNC;
         w_sub_nxt   = B_OFFER;
      end else if (w_accept) begin
         w_sub_nxt = B_WAIT;
      end else if (w_done) begin
         w_sub_nxt = B_OFFER;
         case (r_state)
            S_SYNC:  w_state_nxt = S_LEN;
            S_LEN:   w_state_nxt = S_HI;
            S_HI:    w_state_nxt = S_LO;
            // r_remaining was already decremented when this LO byte was accepted.
            S_LO:    w_state_nxt = (r_remaining != 8'd0) ? S_HI : S_CHK;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // ---- Sequencer: outputs (registered next cycle) ---------------------------
   always_comb begin
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_tx_enable_nxt = (w_state_nxt != S_IDLE) && (w_sub_nxt == B_OFFER);
      w_tx_data_nxt   = r_tx_data;
      // tx_data only changes on entry to a new byte's OFFER; it is held
      // through WAIT_DONE because the UART samples it bit by bit.
      if ((w_start || w_done) && (w_state_nxt != S_IDLE)) begin
         w_tx_data_nxt = frame_byte(w_state_nxt, r_len, w_head, r_chk);
      end
   end

   // ---- Frame length, remaining count and checksum ---------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_remaining <= 8'd0;
      end else if (w_start) begin
         r_remaining <= i_frame_len;
      end else if (w_pop) begin
         r_remaining <= r_remaining - 8'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_start) begin
         r_len <= i_frame_len;
         r_chk <= 8'h00;
      end else if (w_accept && (r_state == S_LEN || r_state == S_HI || r_state == S_LO)) begin
         r_chk <= r_chk ^ r_tx_data;
      end
   end

   assign o_tx_enable = r_tx_enable;
   assign o_tx_data   = r_tx_data;
   assign o_busy      = r_busy;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
// Directed bench for uart_frame_tx (DEPTH=16). A small UART model consumes
// offered bytes, holds tx_ready low for a fixed shift time and records each
// byte; frames are compared with hand-computed byte sequences.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample_data = 12'h000;
   logic        sample_ready;
   logic [7:0]  frame_len = 8'd0;
   logic        tx_ready;
   logic        tx_enable;
   logic [7:0]  tx_data;
   logic        busy;
   logic        overflow;

   // UART model / manual drive selection
   logic        uart_auto = 1'b0;
   logic        man_ready = 1'b1;
   logic        m_ready;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic [7:0]  m_byte = 8'h00;
   logic        m_unstable = 1'b0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   assign tx_ready = uart_auto ? m_ready : man_ready;

   uart_frame_tx #(.DEPTH(16), .SYNC(8'hA5)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_sample_valid (sample_valid),
      .i_sample_data  (sample_data),
      .o_sample_ready (sample_ready),
      .i_frame_len    (frame_len),
      .i_tx_ready     (tx_ready),
      .o_tx_enable    (tx_enable),
      .o_tx_data      (tx_data),
      .o_busy         (busy),
      .o_overflow     (overflow)
   );

   always #5 clk = ~clk;

   // UART model: take a byte when offered, stay busy for 9 cycles while
   // watching that tx_data holds, then return to ready and record the byte.
   always @(posedge clk) begin
      if (!rst || !uart_auto) begin
         m_ready <= 1'b1;
         m_busy  <= 1'b0;
         m_cnt   <= 0;
      end else if (!m_busy) begin
         if (tx_enable === 1'b1) begin
            m_busy  <= 1'b1;
            m_byte  <= tx_data;
            m_ready <= 1'b0;
            m_cnt   <= 8;
         end
      end else begin
         if (tx_data !== m_byte) m_unstable <= 1'b1;
         if (m_cnt == 0) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            rx_q.push_back(m_byte);
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [11:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_busy(input logic val, input int budget, input string tag);
      for (int i = 0; i < budget && busy !== val; i++) @(negedge clk);
      check(tag, 32'(busy), 32'(val));
   endtask

   task automatic wait_txen(input int budget, input string tag);
      for (int i = 0; i < budget && tx_enable !== 1'b1; i++) @(negedge clk);
      check(tag, 32'(tx_enable), 32'd1);
   endtask

   task automatic cmp_frame(input string tag);
      check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic       en_ok;
      logic       dat_ok;
      logic       found;
      logic [7:0] chk;

      // ---- Reset with random inputs ----
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1'($urandom);
         sample_data  = 12'($urandom);
         frame_len    = 8'($urandom);
         man_ready    = 1'($urandom);
         @(negedge clk);
      end
      check("rst_tx_enable", 32'(tx_enable), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_sample_ready", 32'(sample_ready), 32'd1);
      sample_valid = 1'b0;
      frame_len    = 8'd0;
      man_ready    = 1'b1;
      uart_auto    = 1'b1;
      rst          = 1'b1;
      @(negedge clk);

      // ---- Basic frame: N=2, 123 / ABC ----
      rx_q.delete();
      frame_len = 8'd2;
      push(12'h123);
      push(12'hABC);
      wait_busy(1'b1, 20, "basic_busy_rise");
      frame_len = 8'd0;
      wait_busy(1'b0, 500, "basic_busy_fall");
      exp_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h96};
      cmp_frame("basic");
      check("basic_count", 32'(dut.r_count), 32'd0);

      // ---- Fill to full, overflow on 17th push ----
      for (int i = 0; i < 16; i++) push(12'h100 + 12'(i));
      check("full_ready", 32'(sample_ready), 32'd0);
      check("full_count", 32'(dut.r_count), 32'd16);
      check("full_no_ovf", 32'(overflow), 32'd0);
      push(12'h1FF);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(dut.r_count), 32'd16);
      rx_q.delete();
      frame_len = 8'd16;
      wait_busy(1'b1, 20, "full_busy_rise");
      frame_len = 8'd0;
      wait_busy(1'b0, 2000, "full_busy_fall");
      exp_q = '{8'hA5, 8'h10};
      chk = 8'h10;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'h01);
         exp_q.push_back(8'(i));
         chk = chk ^ 8'h01 ^ 8'(i);
      end
      exp_q.push_back(chk);
      cmp_frame("full");
      check("full_ovf_sticky", 32'(overflow), 32'd1);
      check("full_count_end", 32'(dut.r_count), 32'd0);

      // ---- Reset clears sticky overflow ----
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("rst2_overflow", 32'(overflow), 32'd0);

      // ---- Push on the exact cycle of a LO pop ----
      for (int i = 0; i < 8; i++) push(12'h200 + 12'(i));
      check("pp_count_fill", 32'(dut.r_count), 32'd8);
      rx_q.delete();
      frame_len = 8'd4;
      wait_busy(1'b1, 20, "pp_busy_rise");
      frame_len = 8'd0;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (dut.w_pop === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      check("pp_pop_seen", 32'(found), 32'd1);
      check("pp_count_before", 32'(dut.r_count), 32'd8);
      push(12'h2FF);
      check("pp_count_after", 32'(dut.r_count), 32'd8);
      check("pp_no_ovf", 32'(overflow), 32'd0);
      wait_busy(1'b0, 1000, "pp_busy_fall");
      exp_q = '{8'hA5, 8'h04, 8'h02, 8'h00, 8'h02, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
      cmp_frame("pp");
      check("pp_count_end", 32'(dut.r_count), 32'd5);

      // ---- Slow / stalled consumer, manual tx_ready ----
      uart_auto = 1'b0;
      man_ready = 1'b1;
      frame_len = 8'd1;
      wait_txen(20, "stall_offer");
      frame_len = 8'd0;
      check("stall_sync_byte", 32'(tx_data), 32'hA5);
      en_ok  = 1'b1;
      dat_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_enable !== 1'b1) en_ok = 1'b0;
         if (tx_data !== 8'hA5) dat_ok = 1'b0;
      end
      check("stall_en_held", 32'(en_ok), 32'd1);
      check("stall_data_held", 32'(dat_ok), 32'd1);
      man_ready = 1'b0;
      @(negedge clk);
      check("stall_en_drop", 32'(tx_enable), 32'd0);
      en_ok  = 1'b1;
      dat_ok = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (tx_enable !== 1'b0) en_ok = 1'b0;
         if (tx_data !== 8'hA5) dat_ok = 1'b0;
      end
      check("stall_en_low", 32'(en_ok), 32'd1);
      check("stall_data_low", 32'(dat_ok), 32'd1);
      man_ready = 1'b1;
      @(negedge clk);
      check("stall_next_en", 32'(tx_enable), 32'd1);
      check("stall_next_len", 32'(tx_data), 32'h01);
      rx_q.delete();
      uart_auto = 1'b1;
      wait_busy(1'b0, 500, "stall_busy_fall");
      exp_q = '{8'h01, 8'h02, 8'h04, 8'h07};
      cmp_frame("stall");
      check("stall_count_end", 32'(dut.r_count), 32'd4);

      // ---- Mid-frame reset during first HI byte ----
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      rx_q.delete();
      frame_len = 8'd3;
      push(12'h311);
      push(12'h322);
      push(12'h333);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (rx_q.size() == 2 && tx_enable === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      check("mid_hi_offer", 32'(found), 32'd1);
      check("mid_hi_byte", 32'(tx_data), 32'h03);
      rst = 1'b0;
      @(negedge clk);
      check("mid_tx_enable", 32'(tx_enable), 32'd0);
      check("mid_tx_data", 32'(tx_data), 32'h00);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_overflow", 32'(overflow), 32'd0);
      check("mid_sample_ready", 32'(sample_ready), 32'd1);
      check("mid_count", 32'(dut.r_count), 32'd0);
      rst = 1'b1;
      rx_q.delete();
      push(12'h0AB);
      push(12'h0CD);
      push(12'h0EF);
      wait_busy(1'b1, 20, "mid2_busy_rise");
      frame_len = 8'd0;
      wait_busy(1'b0, 1000, "mid2_busy_fall");
      exp_q = '{8'hA5, 8'h03, 8'h00, 8'hAB, 8'h00, 8'hCD, 8'h00, 8'hEF, 8'h8A};
      cmp_frame("mid2");

      check("tx_data_stable", 32'(m_unstable), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Sample framer and byte feeder sitting directly upstream of the UART transmitter in the scope's data path. It buffers 12-bit acquisition samples in a FIFO. Once a full frame's worth of samples is buffered, it emits a fixed-format byte frame: sync, length, sample bytes, checksum. Bytes are handed to the UART one at a time using the UART's `enable`/`write` (ready) handshake, and the byte value is held stable for the UART's whole shift-out.

## Interface
- `DEPTH`, 256: sample FIFO depth in 12-bit words; power of two, ≥4.
- `SYNC`, 8'hA5: first byte of every frame.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  push request; sample is written on a cycle with `sample_valid`=1 and `sample_ready`=1.
- `sample_data`  in  12  acquisition sample.
- `sample_ready`  out  1  FIFO not full; combinational from occupancy count.
- `frame_len`  in  8  samples per frame N; sampled only in IDLE; 0 disables framing.
- `tx_ready`  in  1  UART `write` output (1 = UART idle/ready).
- `tx_enable`  out  1  byte offer to UART `enable`.
- `tx_data`  out  8  byte to UART `dataToSend`.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `overflow`  out  1  sticky; set when a push is attempted while full; cleared only by reset.

## Operation
- FIFO: circular buffer with pointers of log2(DEPTH) bits that wrap naturally. The count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle: the count is unchanged; a push is allowed even when full if a pop happens that cycle.
  - A push when full with no pop: sample dropped, `overflow`←1.
- Frame sequencer states: IDLE, SYNC, LEN, HI, LO, CHK.
  - IDLE → SYNC when `frame_len`≠0 and count ≥ `frame_len`. `frame_len` is latched into `len_q` and the remaining-sample counter is loaded with `len_q`.
  - Because N is latched, changes to `frame_len` mid-frame have no effect.
  - If `frame_len` > DEPTH, the start condition never holds and no frame is sent.
  - Byte values per state:
    - SYNC: `SYNC`.
    - LEN: `len_q`.
    - HI: {4'h0, head[11:8]}.
    - LO: head[7:0].
    - CHK: XOR of the LEN byte and all HI/LO bytes of the frame.
  - Frame = 2N+3 bytes; sample order is FIFO order.
  - The checksum register is cleared at frame start and XOR-updated when each LEN/HI/LO byte is accepted.
  - After LO: the remaining counter is decremented, the FIFO head is popped, and the sequencer goes to HI if remaining≠0, else CHK. CHK → IDLE.
- Byte handshake substates, applied to every byte:
  - OFFER: `tx_data` = byte, `tx_enable`=1. Wait for `tx_ready`=0, which means the UART has started.
  - WAIT_DONE: `tx_enable`=0. Wait for `tx_ready`=1, then advance to the next byte.
  - `tx_data` must not change from OFFER entry until the next byte's OFFER, because the UART reads its input bit-by-bit during transmission.
  - The pop and checksum update for a byte occur on the OFFER→WAIT_DONE transition.
- No timeout: a stalled UART (`tx_ready` stuck 1 in OFFER, or stuck 0 in WAIT_DONE) holds the sequencer indefinitely. Sample pushes continue meanwhile.

## Timing
- Reset values:
  - `tx_enable`=0, `tx_data`=8'h00, `busy`=0, `overflow`=0.
  - FIFO empty, so `sample_ready`=1; state IDLE/OFFER.
- Pushes: the sample is visible in the count the cycle after the push edge. The start condition is evaluated on registered count; `busy`=1 and `tx_enable`=1 (SYNC) on the cycle after the condition is seen.
- All outputs except `sample_ready` are registered.
- `tx_enable` is deasserted on the first cycle after `tx_ready` is sampled 0.
- Next OFFER (`tx_enable`=1, new `tx_data`) is driven on the cycle after `tx_ready` is sampled 1.
- Reset mid-frame:
  - Frame aborted, FIFO flushed, all outputs return to reset values on the next edge.
  - The partially sent frame is not resumed.
- Back-to-back frames: CHK completes → IDLE. A new frame may start on the next cycle if count ≥ N.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → `tx_enable`=0, `tx_data`=00, `busy`=0, `overflow`=0, `sample_ready`=1.
- Basic frame: `frame_len`=2, push 12'h123 then 12'hABC, with the UART model as consumer → bytes A5 02 01 23 0A BC 96 in order; `busy` falls after the 96 stop bit; FIFO count 0.
- Full/overflow: DEPTH=16, `frame_len`=0, push 17 samples → `sample_ready`=0 after the 16th push, 17th dropped, `overflow`=1, count stays 16. Then set `frame_len`=16 → 35 bytes sent, with the first 16 samples in order.
- Simultaneous push/pop: DEPTH=16, `frame_len`=4, 8 samples buffered, push on the exact cycle of a LO-byte pop → count unchanged that cycle; no drop; `overflow`=0.
- Slow/stalled consumer: hold `tx_ready`=1 for 100 cycles after OFFER, then 0 for 5000 cycles → `tx_enable` stays 1 for the first 100 cycles then drops within 1 cycle; `tx_data` constant throughout; no byte skipped.
- Mid-frame reset: `frame_len`=3, assert `rst` during the first HI byte → outputs at reset values next cycle, FIFO empty. After release, a new 3-sample push yields a fresh frame starting with A5.
